// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM duty ramp sequencer: sequencer states and
// the default duty width / PIO register address.
package pwm_pkg;

  localparam int         DUTY_W_DEF        = 8;
  localparam logic [1:0] PIO_DUTY_ADDR_DEF = 2'd0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

endpackage

// File: rtl/pwm_seq_interval_timer.sv
// Inter-step wait timer: loads the programmed interval when a write completes
// and counts down while the sequencer waits; expires on the count of one.
module pwm_seq_interval_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_expire
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_expire = i_dec && (r_count == W'(1));

endmodule

// File: rtl/pwm_duty_sequencer.sv
// Avalon-MM master ramping the pwm_sortie duty register toward a target in
// programmable steps, with a programmable idle gap between writes.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | ready for a ramp request (unless abort is held)
// ST_WRITE | write of r_next on the bus, held while waitrequest is high
// ST_WAIT  | inter-step gap; interval timer running
module pwm_duty_sequencer
  import pwm_pkg::*;
#(
  parameter int         DUTY_W        = DUTY_W_DEF,
  parameter int         INTERVAL_W    = 16,
  parameter logic [1:0] PIO_DUTY_ADDR = PIO_DUTY_ADDR_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [DUTY_W-1:0]     cfg_target,
  input  logic [DUTY_W-1:0]     cfg_step,
  input  logic [INTERVAL_W-1:0] cfg_interval,
  input  logic                  abort,
  output logic [1:0]            avm_address,
  output logic                  avm_chipselect,
  output logic                  avm_write_n,
  output logic [31:0]           avm_writedata,
  input  logic                  avm_waitrequest,
  output logic                  busy,
  output logic                  done,
  output logic [DUTY_W-1:0]     current_duty
);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DUTY_W-1:0]     r_cur;
  logic [DUTY_W-1:0]     r_next;
  logic [DUTY_W-1:0]     r_target;
  logic [DUTY_W-1:0]     r_step;
  logic [INTERVAL_W-1:0] r_interval;
  logic                  r_done;
  logic                  r_abort_pend;
  logic                  w_accept;
  logic                  w_wr_done;
  logic                  w_abort_any;
  logic                  w_tmr_expire;

  // Differences are taken on the ordered pair, so the step never wraps past
  // the target in either direction (saturates near full scale and zero).
  function automatic logic [DUTY_W-1:0] f_step_toward(
    input logic [DUTY_W-1:0] cur,
    input logic [DUTY_W-1:0] tgt,
    input logic [DUTY_W-1:0] stp
  );
    logic [DUTY_W-1:0] res;
    if ((stp == '0) || (cur == tgt))  res = tgt;
    else if (tgt > cur)               res = ((tgt - cur) <= stp) ? tgt : (cur + stp);
    else                              res = ((cur - tgt) <= stp) ? tgt : (cur - stp);
    return res;
  endfunction

  assign w_accept    = cfg_valid && cfg_ready;
  assign w_wr_done   = (r_state == ST_WRITE) && !avm_waitrequest;
  assign w_abort_any = abort || r_abort_pend;

  pwm_seq_interval_timer #(.W(INTERVAL_W)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_wr_done),
    .i_load_val (r_interval),
    .i_dec      (r_state == ST_WAIT),
    .o_expire   (w_tmr_expire)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_state_nxt = ST_WRITE;
      ST_WRITE: begin
        if (w_wr_done) begin
          if (w_abort_any || (r_next == r_target)) w_state_nxt = ST_IDLE;
          else if (r_interval == '0)               w_state_nxt = ST_WRITE;
          else                                     w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (abort)             w_state_nxt = ST_IDLE;
        else if (w_tmr_expire) w_state_nxt = ST_WRITE;
      end
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    cfg_ready      = (r_state == ST_IDLE) && !abort;
    busy           = (r_state != ST_IDLE);
    avm_address    = PIO_DUTY_ADDR;
    avm_chipselect = 1'b0;
    avm_write_n    = 1'b1;
    avm_writedata  = '0;
    if (r_state == ST_WRITE) begin
      avm_chipselect = 1'b1;
      avm_write_n    = 1'b0;
      avm_writedata  = {{(32-DUTY_W){1'b0}}, r_next};
    end
    done           = r_done;
    current_duty   = r_cur;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cur        <= '0;
      r_next       <= '0;
      r_target     <= '0;
      r_step       <= '0;
      r_interval   <= '0;
      r_done       <= 1'b0;
      r_abort_pend <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_target     <= cfg_target;
        r_step       <= cfg_step;
        r_interval   <= cfg_interval;
        r_next       <= f_step_toward(r_cur, cfg_target, cfg_step);
        r_abort_pend <= 1'b0;
      end
      // A write already on the bus cannot be withdrawn; remember the abort.
      if ((r_state == ST_WRITE) && abort) r_abort_pend <= 1'b1;
      if (w_wr_done) begin
        r_cur        <= r_next;
        r_next       <= f_step_toward(r_next, r_target, r_step);
        r_done       <= !w_abort_any && (r_next == r_target);
        r_abort_pend <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// Self-checking bench for pwm_duty_sequencer: directed scenarios plus
// randomized ramps checked against an arithmetic ramp model.
module tb_pwm_duty_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [7:0]  cfg_target = '0;
  logic [7:0]  cfg_step = '0;
  logic [15:0] cfg_interval = '0;
  logic        abort = 1'b0;
  logic [1:0]  avm_address;
  logic        avm_chipselect;
  logic        avm_write_n;
  logic [31:0] avm_writedata;
  logic        avm_waitrequest = 1'b0;
  logic        busy;
  logic        done;
  logic [7:0]  current_duty;

  pwm_duty_sequencer dut (
    .clk             (clk),
    .reset           (reset),
    .cfg_valid       (cfg_valid),
    .cfg_ready       (cfg_ready),
    .cfg_target      (cfg_target),
    .cfg_step        (cfg_step),
    .cfg_interval    (cfg_interval),
    .abort           (abort),
    .avm_address     (avm_address),
    .avm_chipselect  (avm_chipselect),
    .avm_write_n     (avm_write_n),
    .avm_writedata   (avm_writedata),
    .avm_waitrequest (avm_waitrequest),
    .busy            (busy),
    .done            (done),
    .current_duty    (current_duty)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  int unsigned cyc = 0;
  int          stall = 0;
  int          hold = 0;
  int          unstable = 0;
  int          addr_bad = 0;
  int          mdl_cur = 0;
  logic [31:0] hold_val;
  logic [31:0] wr_val[$];
  int unsigned wr_cyc[$];
  int          wr_hold[$];
  int unsigned done_cyc[$];
  int          exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Slave model and bus monitor: stalls each write for `stall` cycles and
  // logs every completed transfer with its completion cycle.
  always @(negedge clk) begin
    if (reset) begin
      hold = 0;
      avm_waitrequest = 1'b0;
    end else if (avm_chipselect && !avm_write_n) begin
      if (hold == 0) hold_val = avm_writedata;
      else if (avm_writedata !== hold_val) unstable++;
      if (avm_address !== 2'd0) addr_bad++;
      if (hold < stall) begin
        avm_waitrequest = 1'b1;
        hold++;
      end else begin
        avm_waitrequest = 1'b0;
        wr_val.push_back(avm_writedata);
        wr_cyc.push_back(cyc);
        wr_hold.push_back(hold + 1);
        hold = 0;
      end
    end else begin
      avm_waitrequest = 1'b0;
      hold = 0;
    end
    if (done) done_cyc.push_back(cyc);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_mon();
    wr_val.delete();
    wr_cyc.delete();
    wr_hold.delete();
    done_cyc.delete();
    unstable = 0;
    addr_bad = 0;
  endtask

  // Ramp model: sequence of duty values the PIO should see.
  task automatic model_ramp(input int cur, input int tgt, input int stp);
    int c;
    exp_q.delete();
    c = cur;
    do begin
      if (stp == 0)      c = tgt;
      else if (tgt > c)  c = (c + stp > tgt) ? tgt : c + stp;
      else               c = (c - stp < tgt) ? tgt : c - stp;
      exp_q.push_back(c);
    end while (c != tgt);
  endtask

  task automatic issue_cfg(input int tgt, input int stp, input int itv, output int unsigned n);
    int t;
    t = 0;
    while (!cfg_ready && t < 200) begin tick(); t++; end
    if (!cfg_ready) begin
      checks++; failures++;
      $display("FAIL cfg_ready_timeout actual=0 required=1");
    end
    cfg_valid    = 1'b1;
    cfg_target   = tgt[7:0];
    cfg_step     = stp[7:0];
    cfg_interval = itv[15:0];
    n = cyc;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int t;
    t = 0;
    while (busy && t < budget) begin tick(); t++; end
    if (busy) begin
      checks++; failures++;
      $display("FAIL idle_timeout busy=1 after %0d cycles required=0", budget);
    end
    tick();
  endtask

  task automatic test_reset();
    checks++; if (current_duty !== 8'd0) begin failures++; $display("FAIL rst_duty actual=%0d required=0", current_duty); end
    checks++; if (avm_chipselect !== 1'b0) begin failures++; $display("FAIL rst_cs actual=%b required=0", avm_chipselect); end
    checks++; if (avm_write_n !== 1'b1) begin failures++; $display("FAIL rst_write_n actual=%b required=1", avm_write_n); end
    checks++; if (avm_writedata !== 32'd0) begin failures++; $display("FAIL rst_wdata actual=%h required=0", avm_writedata); end
    checks++; if (avm_address !== 2'd0) begin failures++; $display("FAIL rst_addr actual=%0d required=0", avm_address); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL rst_busy_done actual=%b%b required=00", busy, done); end
    checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL rst_ready actual=%b required=1", cfg_ready); end
  endtask

  task automatic test_ramp_up();
    int unsigned n;
    int          e[3];
    int unsigned ec[3];
    e[0] = 16; e[1] = 32; e[2] = 40;
    clear_mon();
    stall = 0;
    issue_cfg(40, 16, 3, n);
    ec[0] = n + 1; ec[1] = n + 5; ec[2] = n + 9;
    wait_idle(200);
    checks++; if (wr_val.size() != 3) begin failures++; $display("FAIL up_count actual=%0d required=3", wr_val.size()); end
    for (int i = 0; i < 3; i++) begin
      if (i < wr_val.size()) begin
        checks++;
        if (wr_val[i] !== 32'(e[i]) || wr_cyc[i] != ec[i]) begin
          failures++;
          $display("FAIL up_write%0d actual=%0d@%0d required=%0d@%0d", i, wr_val[i], wr_cyc[i], e[i], ec[i]);
        end
      end
    end
    checks++; if (done_cyc.size() != 1 || done_cyc[0] != n + 10) begin failures++; $display("FAIL up_done count=%0d first=%0d required=1@%0d", done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : 0, n + 10); end
    checks++; if (current_duty !== 8'd40) begin failures++; $display("FAIL up_duty actual=%0d required=40", current_duty); end
    mdl_cur = 40;
  endtask

  task automatic test_ramp_down_stall();
    int unsigned n;
    clear_mon();
    stall = 2;
    issue_cfg(0, 25, 0, n);
    wait_idle(200);
    stall = 0;
    checks++; if (wr_val.size() != 2) begin failures++; $display("FAIL down_count actual=%0d required=2", wr_val.size()); end
    if (wr_val.size() == 2) begin
      checks++; if (wr_val[0] !== 32'd15 || wr_val[1] !== 32'd0) begin failures++; $display("FAIL down_vals actual=%0d,%0d required=15,0", wr_val[0], wr_val[1]); end
      checks++; if (wr_hold[0] != 3 || wr_hold[1] != 3) begin failures++; $display("FAIL down_hold actual=%0d,%0d required=3,3", wr_hold[0], wr_hold[1]); end
      checks++; if (wr_cyc[0] != n + 3 || wr_cyc[1] != n + 6) begin failures++; $display("FAIL down_cyc actual=%0d,%0d required=%0d,%0d", wr_cyc[0], wr_cyc[1], n + 3, n + 6); end
    end
    checks++; if (unstable != 0) begin failures++; $display("FAIL down_stable actual=%0d changes required=0", unstable); end
    checks++; if (done_cyc.size() != 1) begin failures++; $display("FAIL down_done actual=%0d pulses required=1", done_cyc.size()); end
    checks++; if (current_duty !== 8'd0) begin failures++; $display("FAIL down_duty actual=%0d required=0", current_duty); end
    mdl_cur = 0;
  endtask

  task automatic test_saturation();
    int unsigned n;
    clear_mon();
    issue_cfg(250, 0, 0, n);
    wait_idle(50);
    clear_mon();
    issue_cfg(255, 10, 0, n);
    wait_idle(50);
    checks++; if (wr_val.size() != 1 || wr_val[0] !== 32'd255) begin failures++; $display("FAIL sat_write count=%0d first=%0d required=1x255", wr_val.size(), (wr_val.size() > 0) ? wr_val[0] : 0); end
    checks++; if (done_cyc.size() != 1) begin failures++; $display("FAIL sat_done actual=%0d required=1", done_cyc.size()); end
    checks++; if (current_duty !== 8'd255) begin failures++; $display("FAIL sat_duty actual=%0d required=255", current_duty); end
    mdl_cur = 255;
  endtask

  task automatic test_abort_wait();
    int unsigned n;
    int          t;
    issue_cfg(0, 0, 0, n);
    wait_idle(50);
    clear_mon();
    issue_cfg(200, 50, 10, n);
    t = 0;
    while (wr_val.size() == 0 && t < 50) begin tick(); t++; end
    repeat (3) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abw_busy actual=%b required=0", busy); end
    repeat (20) tick();
    checks++; if (wr_val.size() != 1 || wr_val[0] !== 32'd50) begin failures++; $display("FAIL abw_writes count=%0d first=%0d required=1x50", wr_val.size(), (wr_val.size() > 0) ? wr_val[0] : 0); end
    checks++; if (done_cyc.size() != 0) begin failures++; $display("FAIL abw_done actual=%0d required=0", done_cyc.size()); end
    checks++; if (current_duty !== 8'd50) begin failures++; $display("FAIL abw_duty actual=%0d required=50", current_duty); end
    mdl_cur = 50;
  endtask

  task automatic test_abort_write();
    int unsigned n;
    int          t;
    clear_mon();
    stall = 4;
    issue_cfg(150, 30, 2, n);
    t = 0;
    while (!avm_chipselect && t < 10) begin tick(); t++; end
    abort      = 1'b1;
    cfg_valid  = 1'b1;
    cfg_target = 8'd7;
    cfg_step   = 8'd0;
    tick();
    abort     = 1'b0;
    cfg_valid = 1'b0;
    wait_idle(100);
    repeat (10) tick();
    stall = 0;
    checks++; if (wr_val.size() != 1 || wr_val[0] !== 32'd80) begin failures++; $display("FAIL abwr_writes count=%0d first=%0d required=1x80", wr_val.size(), (wr_val.size() > 0) ? wr_val[0] : 0); end
    checks++; if (wr_hold.size() != 1 || wr_hold[0] != 5) begin failures++; $display("FAIL abwr_hold actual=%0d required=5", (wr_hold.size() > 0) ? wr_hold[0] : 0); end
    checks++; if (done_cyc.size() != 0) begin failures++; $display("FAIL abwr_done actual=%0d required=0", done_cyc.size()); end
    checks++; if (current_duty !== 8'd80) begin failures++; $display("FAIL abwr_duty actual=%0d required=80", current_duty); end
    checks++; if (unstable != 0) begin failures++; $display("FAIL abwr_stable actual=%0d required=0", unstable); end
    mdl_cur = 80;
  endtask

  task automatic test_reset_mid_wait();
    int unsigned n;
    int          t;
    clear_mon();
    issue_cfg(200, 10, 20, n);
    t = 0;
    while (wr_val.size() == 0 && t < 50) begin tick(); t++; end
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (avm_chipselect !== 1'b0 || avm_write_n !== 1'b1 || avm_writedata !== 32'd0) begin failures++; $display("FAIL rmw_bus cs=%b wn=%b wd=%h required=0,1,0", avm_chipselect, avm_write_n, avm_writedata); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL rmw_busy_done actual=%b%b required=00", busy, done); end
    checks++; if (current_duty !== 8'd0) begin failures++; $display("FAIL rmw_duty actual=%0d required=0", current_duty); end
    clear_mon();
    issue_cfg(8, 0, 0, n);
    wait_idle(50);
    checks++; if (wr_val.size() != 1 || wr_val[0] !== 32'd8) begin failures++; $display("FAIL rmw_write count=%0d first=%0d required=1x8", wr_val.size(), (wr_val.size() > 0) ? wr_val[0] : 0); end
    checks++; if (done_cyc.size() != 1 || current_duty !== 8'd8) begin failures++; $display("FAIL rmw_done dones=%0d duty=%0d required=1,8", done_cyc.size(), current_duty); end
    mdl_cur = 8;
  endtask

  task automatic test_random();
    int unsigned n;
    int          tgt, stp, itv, bad;
    int unsigned t_start, t_comp;
    for (int it = 0; it < 24; it++) begin
      tgt   = ($urandom_range(0, 3) == 0) ? mdl_cur : int'($urandom_range(0, 255));
      stp   = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(4, 80));
      itv   = int'($urandom_range(0, 4));
      stall = int'($urandom_range(0, 2));
      model_ramp(mdl_cur, tgt, stp);
      clear_mon();
      issue_cfg(tgt, stp, itv, n);
      wait_idle(5000);
      checks++;
      if (wr_val.size() != exp_q.size()) begin
        failures++;
        $display("FAIL rnd%0d_count actual=%0d required=%0d (cur=%0d tgt=%0d step=%0d)", it, wr_val.size(), exp_q.size(), mdl_cur, tgt, stp);
      end else begin
        bad = -1;
        t_start = n + 1;
        t_comp  = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
          t_comp = t_start + stall;
          if (bad < 0 && (wr_val[i] !== 32'(exp_q[i]) || wr_cyc[i] != t_comp)) bad = i;
          t_start = t_comp + itv + 1;
        end
        checks++;
        if (bad >= 0) begin
          failures++;
          $display("FAIL rnd%0d_write%0d actual=%0d@%0d required=%0d", it, bad, wr_val[bad], wr_cyc[bad], exp_q[bad]);
        end
        checks++;
        if (done_cyc.size() != 1 || done_cyc[0] != t_comp + 1) begin
          failures++;
          $display("FAIL rnd%0d_done count=%0d first=%0d required=1@%0d", it, done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : 0, t_comp + 1);
        end
      end
      checks++;
      if (current_duty !== 8'(tgt)) begin
        failures++;
        $display("FAIL rnd%0d_duty actual=%0d required=%0d", it, current_duty, tgt);
      end
      checks++;
      if (addr_bad != 0 || unstable != 0) begin
        failures++;
        $display("FAIL rnd%0d_bus addr_bad=%0d unstable=%0d required=0,0", it, addr_bad, unstable);
      end
      mdl_cur = tgt;
    end
    stall = 0;
  endtask

  initial begin
    repeat (3) tick();
    reset = 1'b0;
    tick();
    test_reset();
    test_ramp_up();
    test_ramp_down_stall();
    test_saturation();
    test_abort_wait();
    test_abort_write();
    test_reset_mid_wait();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
